// File: rtl/mem_responder.sv
// Word-addressed unified memory responder: 1-cycle registered reads, write-protected
// program region, one memory-mapped output register and a post-reset program loader.
module mem_responder #(
    parameter int unsigned              ADDR_W    = 15,
    parameter int unsigned              DATA_W    = 16,
    parameter logic [ADDR_W-1:0]        PROG_BASE = 15'd9216,
    parameter logic [ADDR_W-1:0]        IO_ADDR   = 15'h7FFF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_we,
    output logic [DATA_W-1:0] bus_rdata,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              core_run,
    output logic [DATA_W-1:0] io_out,
    output logic              wp_err,
    output logic              load_ovf
);

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  load_ptr_q, load_ptr_d;
    logic               load_ready_q, load_ready_d;
    logic               core_run_q, core_run_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [DATA_W-1:0]  io_q, io_d;
    logic               wp_err_q, wp_err_d;
    logic               load_ovf_q, load_ovf_d;

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem [0:(2**ADDR_W)-1];

    logic               accept;

    assign accept = load_valid & load_ready_q;

    always_comb begin
        state_d      = state_q;
        load_ptr_d   = load_ptr_q;
        load_ready_d = load_ready_q;
        core_run_d   = core_run_q;
        io_d         = io_q;
        wp_err_d     = wp_err_q;
        load_ovf_d   = load_ovf_q;
        mem_we       = 1'b0;
        mem_waddr    = bus_addr;
        mem_wdata    = bus_wdata;

        // Old contents are sampled here, so same-edge writes are read-first.
        rdata_d = (bus_addr == IO_ADDR) ? io_q : mem[bus_addr];

        case (state_q)
            ST_LOAD: begin
                load_ready_d = 1'b1;
                if (accept) begin
                    if (load_ptr_q == IO_ADDR) begin
                        load_ovf_d = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        mem_waddr  = load_ptr_q;
                        mem_wdata  = load_data;
                        load_ptr_d = load_ptr_q + ADDR_W'(1);
                    end
                    if (load_last) begin
                        state_d      = ST_RUN;
                        load_ready_d = 1'b0;
                        core_run_d   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                load_ready_d = 1'b0;
                core_run_d   = 1'b1;
                if (bus_we) begin
                    if (bus_addr < PROG_BASE) begin
                        mem_we = 1'b1;
                    end else if (bus_addr == IO_ADDR) begin
                        io_d = bus_wdata;
                    end else begin
                        wp_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_LOAD;
            load_ptr_q   <= PROG_BASE;
            load_ready_q <= 1'b0;
            core_run_q   <= 1'b0;
            rdata_q      <= '0;
            io_q         <= '0;
            wp_err_q     <= 1'b0;
            load_ovf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            load_ready_q <= load_ready_d;
            core_run_q   <= core_run_d;
            rdata_q      <= rdata_d;
            io_q         <= io_d;
            wp_err_q     <= wp_err_d;
            load_ovf_q   <= load_ovf_d;
        end
    end

    // Memory array is deliberately not reset so contents survive a reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus_rdata  = rdata_q;
    assign load_ready = load_ready_q;
    assign core_run   = core_run_q;
    assign io_out     = io_q;
    assign wp_err     = wp_err_q;
    assign load_ovf   = load_ovf_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: read expectations are queued when an address
// is presented and popped one edge later when bus_rdata is sampled.
module tb_mem_responder;

    logic        clock;
    logic        reset_n;
    logic [14:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic [15:0] bus_rdata;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        core_run;
    logic [15:0] io_out;
    logic        wp_err;
    logic        load_ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
    } rd_t;

    rd_t sb_q[$];
    int  rd_pending = 0;

    mem_responder dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_we     (bus_we),
        .bus_rdata  (bus_rdata),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .core_run   (core_run),
        .io_out     (io_out),
        .wp_err     (wp_err),
        .load_ovf   (load_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock: outputs are sampled 1ns after the rising edge, and a read
    // presented before this edge is scored against its queued expectation.
    task automatic cyc();
        rd_t e;
        @(posedge clock);
        #1;
        if (rd_pending != 0) begin
            rd_pending = 0;
            e = sb_q.pop_front();
            checks++;
            if (bus_rdata !== e.data) begin
                failures++;
                $display("FAIL read addr=%0d got=%h expected=%h", e.addr, bus_rdata, e.data);
            end
        end
    endtask

    task automatic issue_read(input logic [14:0] a, input logic [15:0] d);
        rd_t e;
        bus_addr = a;
        e.addr   = a;
        e.data   = d;
        sb_q.push_back(e);
        rd_pending = 1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_word({tag, "_rdata"}, bus_rdata, 16'h0000);
        check_word({tag, "_io_out"}, io_out, 16'h0000);
        check_bit({tag, "_core_run"}, core_run, 1'b0);
        check_bit({tag, "_load_ready"}, load_ready, 1'b0);
        check_bit({tag, "_wp_err"}, wp_err, 1'b0);
        check_bit({tag, "_load_ovf"}, load_ovf, 1'b0);
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
        check_bit("ready_after_release", load_ready, 1'b1);
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        cyc();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_we     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        cyc();
        cyc();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        #1;
        check_bit("ready_before_first_edge", load_ready, 1'b0);
        cyc();
        check_bit("ready_first_edge", load_ready, 1'b1);
        check_bit("core_run_in_load", core_run, 1'b0);
    endtask

    task automatic test_load();
        load_word(16'd0, 1'b0);
        load_word(16'd2, 1'b0);
        check_bit("ready_mid_load", load_ready, 1'b1);
        load_word(16'd65347, 1'b1);
        check_bit("ready_after_last", load_ready, 1'b0);
        check_bit("core_run_after_last", core_run, 1'b1);
        issue_read(15'd9216, 16'd0);
        cyc();
        issue_read(15'd9217, 16'd2);
        cyc();
        issue_read(15'd9218, 16'd65347);
        cyc();
    endtask

    task automatic test_write();
        bus_we    = 1'b1;
        bus_addr  = 15'd5;
        bus_wdata = 16'h00AB;
        cyc();
        bus_we = 1'b0;
        issue_read(15'd5, 16'h00AB);
        cyc();
        bus_we    = 1'b1;
        bus_wdata = 16'h00CD;
        issue_read(15'd5, 16'h00AB);
        cyc();
        bus_we = 1'b0;
        issue_read(15'd5, 16'h00CD);
        cyc();
        check_bit("no_wp_err_low_write", wp_err, 1'b0);
    endtask

    task automatic test_write_protect();
        bus_we    = 1'b1;
        bus_addr  = 15'd9216;
        bus_wdata = 16'h1234;
        cyc();
        bus_we = 1'b0;
        check_bit("wp_err_set", wp_err, 1'b1);
        issue_read(15'd9216, 16'd0);
        cyc();
        for (int i = 0; i < 4; i++) cyc();
        check_bit("wp_err_sticky", wp_err, 1'b1);
    endtask

    task automatic test_io();
        bus_we    = 1'b1;
        bus_addr  = 15'h7FFF;
        bus_wdata = 16'h5A5A;
        cyc();
        bus_we = 1'b0;
        check_word("io_out_written", io_out, 16'h5A5A);
        issue_read(15'h7FFF, 16'h5A5A);
        cyc();
    endtask

    task automatic test_load_gaps();
        do_reset();
        check_bit("core_run_reload", core_run, 1'b0);
        // Bus writes are driven alongside the gapped loader stream and must be ignored.
        bus_we     = 1'b1;
        bus_addr   = 15'd5;
        bus_wdata  = 16'hFFFF;
        load_valid = 1'b1;
        load_data  = 16'h1111;
        cyc();
        bus_addr   = 15'h7FFF;
        load_valid = 1'b0;
        load_data  = 16'h9999;
        cyc();
        bus_addr   = 15'd9216;
        bus_wdata  = 16'hBEEF;
        load_valid = 1'b1;
        load_data  = 16'h2222;
        cyc();
        load_valid = 1'b0;
        bus_we     = 1'b0;
        check_bit("gap_ready", load_ready, 1'b1);
        check_bit("gap_core_run", core_run, 1'b0);
        check_bit("gap_wp_err", wp_err, 1'b0);
        check_word("gap_io_out", io_out, 16'h0000);
        issue_read(15'd9216, 16'h1111);
        cyc();
        issue_read(15'd9217, 16'h2222);
        cyc();
        issue_read(15'd9218, 16'd65347);
        cyc();
        issue_read(15'd5, 16'h00CD);
        cyc();
        issue_read(15'h7FFF, 16'h0000);
        cyc();
    endtask

    task automatic test_overflow();
        do_reset();
        load_valid = 1'b1;
        load_last  = 1'b0;
        for (int i = 0; i < 23552; i++) begin
            load_data = 16'(i) ^ 16'hA5A5;
            cyc();
            if (i == 23550) check_bit("ovf_before_last_slot", load_ovf, 1'b0);
        end
        check_bit("ovf_set", load_ovf, 1'b1);
        check_bit("ovf_ready_held", load_ready, 1'b1);
        load_valid = 1'b0;
        issue_read(15'd9216, 16'h0000 ^ 16'hA5A5);
        cyc();
        issue_read(15'd32766, 16'd23550 ^ 16'hA5A5);
        cyc();
        issue_read(15'h7FFF, 16'h0000);
        cyc();
        load_valid = 1'b1;
        load_data  = 16'h7777;
        cyc();
        cyc();
        check_bit("ovf_sticky", load_ovf, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midstream_reset");
        load_valid = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_load();
        test_write();
        test_write_protect();
        test_io();
        test_load_gaps();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder that sits on the far side of the core's bus and answers its instruction fetches, data reads and data writes. It provides a 32K x 16 unified memory with a registered, one-cycle read latency and a write-protected program region starting at `PROG_BASE`. It also exposes one memory-mapped output register. After reset it runs a loader phase that fills the program region through a valid/ready stream and holds the core off until the last word arrives.

## Interface
Parameters:
- `ADDR_W`, 15, bus address width in words
- `DATA_W`, 16, word width
- `PROG_BASE`, 15'd9216, first program word; also the loader start address
- `IO_ADDR`, 15'h7FFF, address of the memory-mapped output register

Ports:
- `clock`  in  1  single clock; all state changes on rising edge
- `reset_n`  in  1  reset; asynchronous, active-low
- `bus_addr`  in  15  word address from core
- `bus_wdata`  in  16  write data from core
- `bus_we`  in  1  write enable from core
- `bus_rdata`  out  16  registered read data to core
- `load_valid`  in  1  loader word present
- `load_data`  in  16  loader word
- `load_last`  in  1  qualifies final loader word
- `load_ready`  out  1  responder accepts a loader word
- `core_run`  out  1  core may execute; 0 holds core idle
- `io_out`  out  16  memory-mapped output register
- `wp_err`  out  1  sticky flag: core write to protected region
- `load_ovf`  out  1  sticky flag: loader ran past the last storable word

## Operation
- Two-state FSM:
  - LOAD is entered on reset.
  - LOAD -> RUN on the edge that accepts a word with `load_last`=1.
  - RUN is held until reset; there is no return path.
- Loader transfer (LOAD only): a word is accepted on an edge where `load_valid & load_ready`.
  - The word is written to `mem[load_ptr]`.
  - `load_ptr` then increments. It resets to `PROG_BASE`.
- Loader overflow: when `load_ptr == IO_ADDR`, an accepted word is handshaken but not stored.
  - `load_ovf` is set.
  - `load_ptr` saturates at `IO_ADDR`.
- Bus read, any state: `bus_rdata` on edge N+1 equals `mem[bus_addr]` sampled at edge N.
  - If `bus_addr == IO_ADDR`, the value is `io_out` instead.
- Bus write (RUN only; ignored in LOAD), with `bus_we`=1 at edge N:
  - `bus_addr < PROG_BASE`: `mem[bus_addr] <= bus_wdata`.
  - `bus_addr == IO_ADDR`: `io_out <= bus_wdata`; memory is untouched.
  - Otherwise (protected): no write; `wp_err` is set.
- Read-during-write at the same address on one edge is read-first: `bus_rdata` returns the old value.
- Loader write and bus read at the same address on one edge is also read-first.
- Sticky flags clear only on reset.
- Memory contents are not reset. Unwritten words read as X in simulation; the bench must not depend on them.

## Timing
- Reset values, asserted asynchronously:
  - `bus_rdata`=0, `io_out`=0, `core_run`=0, `load_ready`=0, `wp_err`=0, `load_ovf`=0.
  - FSM = LOAD, `load_ptr`=`PROG_BASE`.
- `load_ready` is registered. It rises on the first edge after `reset_n` deasserts and stays 1 throughout LOAD.
- On the edge accepting the `load_last` word, both registered outputs change:
  - `load_ready` goes to 0.
  - `core_run` goes to 1, visible in the following cycle.
- Loader throughput: one word per cycle.
- `load_valid` with `load_ready`=0 is a no-op, and the loader must hold its word. The responder never drops a word that has been handshaken.
- Read latency: exactly 1 cycle, with no wait states. The core presents an address in cycle N and samples data in cycle N+1.
- Write commit: the write lands on the edge where `bus_we`=1. A read of that address issued on the next edge returns the new data.
- `wp_err` and `load_ovf` assert on the same edge as the offending write or accept.
- Reset asserted mid-load or mid-run: the FSM returns to LOAD and `load_ptr` to `PROG_BASE` immediately. Already-written memory words are retained, but a reload overwrites them.

## Test plan
- Reset release, then load 3 words 0, 2, 65347 with `load_last` on the 3rd -> `load_ready`=0 and `core_run`=1 after the 3rd accept. Bus reads of 9216, 9217 and 9218 return 0, 2 and 65347, each one cycle after the address.
- In RUN, write 16'h00AB to address 5, then read 5 on the next cycle -> `bus_rdata`=16'h00AB. On a same-edge read+write to 5 with new data 16'h00CD, `bus_rdata` shows 16'h00AB.
- In RUN, write 16'h1234 to 9216 -> `wp_err`=1 and `mem[9216]` unchanged (still 0). `wp_err` stays 1 until `reset_n`=0.
- In RUN, write 16'h5A5A to 15'h7FFF -> `io_out`=16'h5A5A on the next cycle. A read of 15'h7FFF returns 16'h5A5A.
- Loader with gaps: `load_valid` toggles 1,0,1 -> only 2 words are written, at 9216 and 9217. Bus writes attempted during LOAD change nothing.
- Stream 23552 words without `load_last` -> the word destined for 15'h7FFF is not stored, `load_ovf`=1, and `load_ready` stays 1. Asserting `reset_n`=0 mid-stream returns all outputs to reset values asynchronously.
